// File: rtl/spike_enc_pkg.sv
// spike_enc_pkg
//   Shared definitions for the spike_rate_encoder block: FSM state type,
//   intensity width, and the stochastic-mode LFSR constants and helpers.
//   The LFSR items are only referenced when SPIKE_RATE_ENCODER_LFSR_EN is
//   defined.
package spike_enc_pkg;

  localparam int unsigned INT_W = 8;

  localparam logic [INT_W-1:0] LFSR_SEED = 8'hA5;
  // Galois taps for x^8+x^6+x^5+x^4+1, right-shifting form
  localparam logic [INT_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic [INT_W-1:0] lfsr_step(input logic [INT_W-1:0] x);
    logic [INT_W-1:0] s;
    s = x >> 1;
    if (x[0]) s = s ^ LFSR_TAPS;
    return s;
  endfunction

  function automatic logic [INT_W-1:0] rotl(input logic [INT_W-1:0] x,
                                            input int unsigned n);
    logic [2*INT_W-1:0] d;
    d = {x, x} << (n % INT_W);
    return d[2*INT_W-1:INT_W];
  endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// spike_rate_encoder_if
//   Host-side bundle of the spike_rate_encoder.
//   master: host (drives load_valid/load_ch/load_value/start/abort)
//   slave : encoder (drives load_ready/busy/done/spike_out)
interface spike_rate_encoder_if
  import spike_enc_pkg::*;
#(
  parameter int unsigned N_CH = 2
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             load_valid;
  logic             load_ready;
  logic [CH_W-1:0]  load_ch;
  logic [INT_W-1:0] load_value;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [N_CH-1:0]  spike_out;

  modport master (
    output load_valid, load_ch, load_value, start, abort,
    input  load_ready, busy, done, spike_out
  );

  modport slave (
    input  load_valid, load_ch, load_value, start, abort,
    output load_ready, busy, done, spike_out
  );

endinterface

// File: rtl/spike_enc_channel.sv
// spike_enc_channel
//   One rate-coded spike channel: holds the 8-bit intensity and produces a
//   registered spike per update.
//   Default build: phase accumulator, spike = carry out of acc + value.
//   SPIKE_RATE_ENCODER_LFSR_EN defined: spike = rotl(lfsr, ROT) < value.
//   Ports: clk, reset (sync, active-high), wr_en/wr_value (intensity write),
//   clr (zero spike and accumulator), upd (perform one update),
//   lfsr (shared LFSR state, stochastic mode only), spike (registered).
module spike_enc_channel
  import spike_enc_pkg::*;
`ifdef SPIKE_RATE_ENCODER_LFSR_EN
#(
  parameter int unsigned ROT = 0
)
`endif
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [INT_W-1:0] wr_value,
  input  logic             clr,
  input  logic             upd,
`ifdef SPIKE_RATE_ENCODER_LFSR_EN
  input  logic [INT_W-1:0] lfsr,
`endif
  output logic             spike
);

  logic [INT_W-1:0] value;

  always_ff @(posedge clk) begin
    if (reset) value <= '0;
    else if (wr_en) value <= wr_value;
  end

`ifdef SPIKE_RATE_ENCODER_LFSR_EN
  always_ff @(posedge clk) begin
    if (reset || clr) spike <= 1'b0;
    else if (upd) spike <= (rotl(lfsr, ROT) < value);
  end
`else
  logic [INT_W-1:0] acc;
  logic [INT_W:0]   sum;

  always_comb begin
    sum = {1'b0, acc} + {1'b0, value};
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc   <= '0;
      spike <= 1'b0;
    end else if (upd) begin
      acc   <= sum[INT_W-1:0];
      spike <= sum[INT_W];
    end
  end
`endif

endmodule

// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
//   Rate-coding spike transmitter. Intensities are loaded per channel in
//   IDLE; start runs WINDOW updates, each producing one registered spike per
//   channel, followed by a one-cycle done pulse.
//   Ports: clk, reset (sync, active-high), bus (spike_rate_encoder_if.slave:
//   load handshake, start/abort, busy/done, spike_out[N_CH]).
//   Optional macro SPIKE_RATE_ENCODER_LFSR_EN selects stochastic mode with a
//   shared 8-bit Galois LFSR instead of per-channel accumulators.
module spike_rate_encoder
  import spike_enc_pkg::*;
#(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned WINDOW = 256
)(
  input logic                 clk,
  input logic                 reset,
  spike_rate_encoder_if.slave bus
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [15:0] LAST = 16'(WINDOW - 1);

  state_t      state;
  logic [15:0] win_cnt;
  logic        busy_q;
  logic        done_q;
  logic        ready_q;

  logic        start_acc;
  logic        run_upd;
  logic        clr;
  logic        load_we;
  logic [N_CH-1:0] spike_vec;

  // clr zeroes spikes when a run starts, is aborted, or leaves DONE.
  always_comb begin
    start_acc = 1'b0;
    run_upd   = 1'b0;
    clr       = 1'b0;
    load_we   = bus.load_valid & ready_q;
    case (state)
      ST_IDLE: begin
        start_acc = bus.start;
        clr       = bus.start;
      end
      ST_RUN: begin
        run_upd = ~bus.abort;
        clr     = bus.abort;
      end
      ST_DONE: clr = 1'b1;
      default: clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      win_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_RUN;
            win_cnt <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            win_cnt <= win_cnt + 16'd1;
            if (win_cnt == LAST) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef SPIKE_RATE_ENCODER_LFSR_EN
  logic [INT_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset || start_acc) lfsr <= LFSR_SEED;
    else if (run_upd) lfsr <= lfsr_step(lfsr);
  end
`endif

  // Out-of-range load_ch matches no channel, so the write is dropped while
  // the handshake still completes.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ch_we;
    assign ch_we = load_we && (bus.load_ch == CH_W'(i));

    spike_enc_channel
`ifdef SPIKE_RATE_ENCODER_LFSR_EN
      #(.ROT(3 * i))
`endif
    u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (ch_we),
      .wr_value (bus.load_value),
      .clr      (clr),
      .upd      (run_upd),
`ifdef SPIKE_RATE_ENCODER_LFSR_EN
      .lfsr     (lfsr),
`endif
      .spike    (spike_vec[i])
    );
  end

  assign bus.load_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.spike_out  = spike_vec;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb_spike_rate_encoder
//   Self-checking bench: a behavioural model derived from the run/window
//   rules predicts busy/load_ready/done/spike_out every cycle; directed runs
//   pin spike totals and timing with literal values; randomized runs add
//   random intensities, aborts and refused mid-run loads.
module tb_spike_rate_encoder;
  import spike_enc_pkg::*;

  localparam int unsigned W = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spike_rate_encoder_if #(.N_CH(2)) bus ();

  spike_rate_encoder #(.N_CH(2), .WINDOW(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase = 0;      // 0 idle, 1 running, 2 done
  int m_k     = 0;      // updates performed in the current run
  int m_val[2] = '{0, 0};

  // Spike for update k (1-based): accumulator form emits a spike whenever
  // floor(k*v/256) steps up.
  function automatic int exp_spike(input int ch, input int k, input int v);
`ifdef SPIKE_RATE_ENCODER_LFSR_EN
    logic [7:0] l;
    l = LFSR_SEED;
    for (int j = 1; j < k; j++) l = lfsr_step(l);
    return (int'(rotl(l, 3 * ch)) < v) ? 1 : 0;
`else
    if (ch < 0) return 0;
    return (k * v) / 256 - ((k - 1) * v) / 256;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_k     = 0;
      m_val   = '{0, 0};
    end else begin
      case (m_phase)
        0: begin
          if (bus.load_valid) m_val[bus.load_ch] = int'(bus.load_value);
          if (bus.start) begin
            m_phase = 1;
            m_k     = 0;
          end
        end
        1: begin
          if (bus.abort) m_phase = 0;
          else begin
            m_k++;
            if (m_k == W) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic chk_en = 1'b0;
  int sc0 = 0, sc1 = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] es;
      es = 2'b00;
      if (m_phase != 0 && m_k >= 1) begin
        es[0] = exp_spike(0, m_k, m_val[0]) != 0;
        es[1] = exp_spike(1, m_k, m_val[1]) != 0;
      end
      check("busy",       32'(bus.busy),       32'(m_phase != 0));
      check("load_ready", 32'(bus.load_ready), 32'(m_phase == 0));
      check("done",       32'(bus.done),       32'(m_phase == 2));
      check("spike_out",  32'(bus.spike_out),  32'(es));
      sc0 += int'(bus.spike_out[0]);
      sc1 += int'(bus.spike_out[1]);
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    sc0 = 0;
    sc1 = 0;
    done_cnt = 0;
  endtask

  task automatic do_load(input int ch, input int v);
    bus.load_valid = 1'b1;
    bus.load_ch    = ch[0];
    bus.load_value = v[7:0];
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic do_start();
    clear_counts();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < int'(W) + 20) begin
      tick();
      n++;
    end
    if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.busy),       32'd0);
    check({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
    check({tag, "_done"},  32'(bus.done),       32'd0);
    check({tag, "_spike"}, 32'(bus.spike_out),  32'd0);
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_ch    = '0;
    bus.load_value = '0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    reset          = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("reset");

    // 64 / 192 over a 256-update window
    do_load(0, 64);
    do_load(1, 192);
    do_start();
    wait_idle();
`ifndef SPIKE_RATE_ENCODER_LFSR_EN
    check("cnt64",  32'(sc0), 32'd64);
    check("cnt192", 32'(sc1), 32'd192);
`endif
    check("done_once",   32'(done_cnt),             32'd1);
    check("done_timing", 32'(done_cyc - start_cyc), 32'(W));

    // 128 alternates starting with a spike on update 2
    do_load(0, 128);
    do_start();
    tick();
`ifndef SPIKE_RATE_ENCODER_LFSR_EN
    check("pat128_u1", 32'(bus.spike_out[0]), 32'd0);
    tick();
    check("pat128_u2", 32'(bus.spike_out[0]), 32'd1);
    tick();
    check("pat128_u3", 32'(bus.spike_out[0]), 32'd0);
`endif
    wait_idle();
`ifndef SPIKE_RATE_ENCODER_LFSR_EN
    check("cnt128", 32'(sc0), 32'd128);
`endif

    // 0 / 255 with a mid-run load that must be refused
    do_load(0, 0);
    do_load(1, 255);
    do_start();
    repeat (10) tick();
    check("ready_midrun", 32'(bus.load_ready), 32'd0);
    bus.load_valid = 1'b1;
    bus.load_ch    = 1'b0;
    bus.load_value = 8'd77;
    tick();
    bus.load_valid = 1'b0;
    wait_idle();
    check("cnt0",   32'(sc0), 32'd0);
`ifndef SPIKE_RATE_ENCODER_LFSR_EN
    check("cnt255", 32'(sc1), 32'd255);
`endif

    // load and start in the same cycle; ch0 must still be 0
    clear_counts();
    bus.load_valid = 1'b1;
    bus.load_ch    = 1'b1;
    bus.load_value = 8'd100;
    bus.start      = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
    wait_idle();
    check("dropped_load", 32'(sc0), 32'd0);
`ifndef SPIKE_RATE_ENCODER_LFSR_EN
    check("cnt100", 32'(sc1), 32'd100);
`endif

    // abort sampled at the 50th update edge
    do_load(0, 64);
    do_load(1, 192);
    do_start();
    repeat (49) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_idle_outputs("abort");
    repeat (3) tick();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    do_start();
    wait_idle();
`ifndef SPIKE_RATE_ENCODER_LFSR_EN
    check("post_abort_cnt0", 32'(sc0), 32'd64);
    check("post_abort_cnt1", 32'(sc1), 32'd192);
`endif

    // reset mid-run clears intensities
    do_start();
    repeat (100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("midreset");
    do_start();
    wait_idle();
    check("post_reset_cnt0", 32'(sc0), 32'd0);
    check("post_reset_cnt1", 32'(sc1), 32'd0);
    check("post_reset_done", 32'(done_cnt), 32'd1);

    // randomized runs: random loads, aborts (incl. in DONE), refused loads
    for (int r = 0; r < 8; r++) begin
      int nl, ab;
      nl = int'($urandom_range(0, 3));
      for (int j = 0; j < nl; j++)
        do_load(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W + 1)) : 0;
      do_start();
      for (int k = 1; k <= int'(W) + 1; k++) begin
        bus.abort      = (k == ab);
        bus.load_valid = ($urandom_range(0, 15) == 0);
        bus.load_ch    = 1'($urandom_range(0, 1));
        bus.load_value = 8'($urandom_range(0, 255));
        tick();
        bus.abort      = 1'b0;
        bus.load_valid = 1'b0;
        if (!bus.busy) break;
      end
      wait_idle();
      check("rand_done_cnt", 32'(done_cnt), (ab == 0) ? 32'd1 : 32'd0);
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
